// File: rtl/mm_stim_bank_if.sv
// mm_stim_bank_if: CPU data-memory port plus bench stimulus/capture port
// for mm_stim_bank. The slave modport is the bank side. The master modport
// is the CPU/bench side.
interface mm_stim_bank_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NUM_CH = 4
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // CPU side
    logic [ADDR_W-1:0] addr;
    logic              mm_re;
    logic              mm_we;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    // bench side
    logic              stim_push;
    logic [CH_W-1:0]   stim_ch;
    logic [DATA_W-1:0] stim_data;
    logic              cap_pop;
    logic [DATA_W-1:0] cap_data;
    logic              cap_valid;
    logic              irq;

    modport slave (
        input  addr, mm_re, mm_we, wdata, stim_push, stim_ch, stim_data, cap_pop,
        output rdata, cap_data, cap_valid, irq
    );

    modport master (
        output addr, mm_re, mm_we, wdata, stim_push, stim_ch, stim_data, cap_pop,
        input  rdata, cap_data, cap_valid, irq
    );
endinterface

// File: rtl/mm_stim_bank.sv
// mm_stim_bank: memory-mapped stimulus/capture bank with NUM_CH channels.
// Each channel has a stimulus FIFO that the bench fills and CPU DATA reads
// drain. It also has a capture FIFO that CPU DATA writes fill and the bench
// drains. A per-channel read mode (FIFO / INCR / CONST) selects the source
// of DATA reads.
// Optional feature: define MMSTIM_IRQ_EN to build the registered error
// interrupt. Without it, irq is tied low.

// One channel: two FIFOs, counter, const register, mode and sticky flags.
module mm_stim_ch #(
    parameter int              DATA_W       = 16,
    parameter int              DEPTH        = 8,
    parameter logic [DATA_W-1:0] DEFAULT_DATA = 16'hAAAA
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_rd_i,
    input  logic              data_wr_i,
    input  logic              ctrl_wr_i,
    input  logic              seed_wr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              stim_push_i,
    input  logic [DATA_W-1:0] stim_data_i,
    input  logic              cap_pop_i,
    output logic [DATA_W-1:0] rd_val_o,
    output logic [DATA_W-1:0] cnt_o,
    output logic [DATA_W-1:0] cap_head_o,
    output logic [1:0]        mode_o,
    output logic [5:0]        status_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {M_FIFO = 2'd0, M_INCR = 2'd1, M_CONST = 2'd2, M_FIFO3 = 2'd3} mode_e;

    logic [DATA_W-1:0] stim_mem [DEPTH];
    logic [DATA_W-1:0] cap_mem  [DEPTH];
    logic [AW:0]       stim_wp_q, stim_wp_d, stim_rp_q, stim_rp_d;
    logic [AW:0]       cap_wp_q,  cap_wp_d,  cap_rp_q,  cap_rp_d;
    logic [DATA_W-1:0] cnt_q, cnt_d, const_q, const_d;
    mode_e             mode_q, mode_d;
    logic              udf_q, udf_d, ovf_q, ovf_d;

    logic stim_empty, stim_full, cap_empty, cap_full, is_fifo;
    logic stim_pop, stim_wr, cap_pop, cap_wr;

    assign stim_empty = (stim_wp_q == stim_rp_q);
    assign stim_full  = (stim_wp_q[AW] != stim_rp_q[AW]) && (stim_wp_q[AW-1:0] == stim_rp_q[AW-1:0]);
    assign cap_empty  = (cap_wp_q == cap_rp_q);
    assign cap_full   = (cap_wp_q[AW] != cap_rp_q[AW]) && (cap_wp_q[AW-1:0] == cap_rp_q[AW-1:0]);
    assign is_fifo    = (mode_q == M_FIFO) || (mode_q == M_FIFO3);

    // A pop on a full FIFO frees a slot in the same edge, so the push is taken.
    assign stim_pop = data_rd_i && is_fifo && !stim_empty;
    assign stim_wr  = stim_push_i && (!stim_full || stim_pop);
    assign cap_pop  = cap_pop_i && !cap_empty;
    assign cap_wr   = data_wr_i && (!cap_full || cap_pop);

    assign cnt_o      = cnt_q;
    assign cap_head_o = cap_mem[cap_rp_q[AW-1:0]];
    assign mode_o     = mode_q;
    assign status_o   = {udf_q, ovf_q, cap_full, cap_empty, stim_full, stim_empty};

    // DATA read value from the pre-edge state
    always_comb begin
        rd_val_o = DEFAULT_DATA;
        case (mode_q)
            M_INCR:  rd_val_o = cnt_q;
            M_CONST: rd_val_o = const_q;
            default: rd_val_o = stim_empty ? DEFAULT_DATA : stim_mem[stim_rp_q[AW-1:0]];
        endcase
    end

    // next state for pointers, counter, const, mode and sticky flags
    always_comb begin
        stim_wp_d = stim_wp_q + (AW+1)'(stim_wr);
        stim_rp_d = stim_rp_q + (AW+1)'(stim_pop);
        cap_wp_d  = cap_wp_q + (AW+1)'(cap_wr);
        cap_rp_d  = cap_rp_q + (AW+1)'(cap_pop);
        cnt_d     = cnt_q;
        const_d   = const_q;
        mode_d    = mode_q;
        udf_d     = udf_q;
        ovf_d     = ovf_q;
        if (seed_wr_i) begin
            cnt_d   = wdata_i;
            const_d = wdata_i;
        end else if (data_rd_i && mode_q == M_INCR) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (ctrl_wr_i) begin
            mode_d = mode_e'(wdata_i[1:0]);
            if (wdata_i[15]) begin
                udf_d = 1'b0;
                ovf_d = 1'b0;
            end
        end
        if (data_rd_i && is_fifo && stim_empty) udf_d = 1'b1;
        if (data_wr_i && !cap_wr)               ovf_d = 1'b1;
    end

    // channel state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stim_wp_q <= '0;
            stim_rp_q <= '0;
            cap_wp_q  <= '0;
            cap_rp_q  <= '0;
            cnt_q     <= '0;
            const_q   <= DEFAULT_DATA;
            mode_q    <= M_FIFO;
            udf_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            stim_wp_q <= stim_wp_d;
            stim_rp_q <= stim_rp_d;
            cap_wp_q  <= cap_wp_d;
            cap_rp_q  <= cap_rp_d;
            cnt_q     <= cnt_d;
            const_q   <= const_d;
            mode_q    <= mode_d;
            udf_q     <= udf_d;
            ovf_q     <= ovf_d;
        end
    end

    // FIFO storage, no reset: contents are meaningless while empty
    always_ff @(posedge clk) begin
        if (stim_wr) stim_mem[stim_wp_q[AW-1:0]] <= stim_data_i;
        if (cap_wr)  cap_mem[cap_wp_q[AW-1:0]]   <= wdata_i;
    end
endmodule

module mm_stim_bank #(
    parameter int                DATA_W       = 16,
    parameter int                ADDR_W       = 16,
    parameter int                NUM_CH       = 4,
    parameter int                DEPTH        = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 16'hC000,
    parameter logic [DATA_W-1:0] DEFAULT_DATA = 16'hAAAA
) (
    input logic           clk,
    input logic           rst,
    mm_stim_bank_if.slave bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] WIN_HI = WIN_LO + (ADDR_W+1)'(4 * NUM_CH);

    logic            hit;
    logic [CH_W-1:0] sel_ch;
    logic [1:0]      sel_reg;

    logic [NUM_CH-1:0][DATA_W-1:0] rd_val, cnt, cap_head;
    logic [NUM_CH-1:0][1:0]        mode;
    logic [NUM_CH-1:0][5:0]        status;
    logic [NUM_CH-1:0]             cap_take;

    logic [DATA_W-1:0] rdata_q, rdata_d, cap_data_q, cap_data_d;
    logic              cap_valid_q, cap_valid_d;

    assign hit     = ({1'b0, bus.addr} >= WIN_LO) && ({1'b0, bus.addr} < WIN_HI);
    assign sel_ch  = (NUM_CH > 1) ? bus.addr[2 +: CH_W] : '0;
    assign sel_reg = bus.addr[1:0];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic cpu_sel, bench_sel;
        assign cpu_sel     = hit && (sel_ch == CH_W'(i));
        assign bench_sel   = (bus.stim_ch == CH_W'(i));
        assign cap_take[i] = bus.cap_pop && bench_sel && !status[i][2];

        mm_stim_ch #(
            .DATA_W       (DATA_W),
            .DEPTH        (DEPTH),
            .DEFAULT_DATA (DEFAULT_DATA)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .data_rd_i   (cpu_sel && bus.mm_re && sel_reg == 2'd0),
            .data_wr_i   (cpu_sel && bus.mm_we && sel_reg == 2'd0),
            .ctrl_wr_i   (cpu_sel && bus.mm_we && sel_reg == 2'd2),
            .seed_wr_i   (cpu_sel && bus.mm_we && sel_reg == 2'd3),
            .wdata_i     (bus.wdata),
            .stim_push_i (bus.stim_push && bench_sel),
            .stim_data_i (bus.stim_data),
            .cap_pop_i   (bus.cap_pop && bench_sel),
            .rd_val_o    (rd_val[i]),
            .cnt_o       (cnt[i]),
            .cap_head_o  (cap_head[i]),
            .mode_o      (mode[i]),
            .status_o    (status[i])
        );
    end

    // CPU read mux; rdata only moves on a read strobe
    always_comb begin
        rdata_d = rdata_q;
        if (bus.mm_re) begin
            rdata_d = '0;
            if (hit) begin
                case (sel_reg)
                    2'd0:    rdata_d = rd_val[sel_ch];
                    2'd1:    rdata_d = DATA_W'(status[sel_ch]);
                    2'd2:    rdata_d = DATA_W'(mode[sel_ch]);
                    default: rdata_d = cnt[sel_ch];
                endcase
            end
        end
    end

    // bench capture pop; cap_data holds between valid pulses
    always_comb begin
        cap_valid_d = |cap_take;
        cap_data_d  = cap_data_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cap_take[i]) cap_data_d = cap_head[i];
        end
    end

    // output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q     <= '0;
            cap_data_q  <= '0;
            cap_valid_q <= 1'b0;
        end else begin
            rdata_q     <= rdata_d;
            cap_data_q  <= cap_data_d;
            cap_valid_q <= cap_valid_d;
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.cap_data  = cap_data_q;
    assign bus.cap_valid = cap_valid_q;

`ifdef MMSTIM_IRQ_EN
    logic irq_q, irq_d;

    // OR of all sticky error flags, one cycle behind them
    always_comb begin
        irq_d = 1'b0;
        for (int i = 0; i < NUM_CH; i++) irq_d = irq_d | status[i][5] | status[i][4];
    end

    // interrupt register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= irq_d;
    end

    assign bus.irq = irq_q;
`else
    assign bus.irq = 1'b0;
`endif
endmodule

// File: tb/tb_mm_stim_bank.sv
// tb_mm_stim_bank: directed test of mm_stim_bank against a queue-based
// behavioural model, plus literal expectations along the scripted sequence.
module tb_mm_stim_bank;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    mm_stim_bank_if #(.DATA_W(16), .ADDR_W(16), .NUM_CH(4)) bus ();

    mm_stim_bank #(
        .DATA_W(16), .ADDR_W(16), .NUM_CH(4), .DEPTH(8),
        .BASE_ADDR(16'hC000), .DEFAULT_DATA(16'hAAAA)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_stim [4][$];
    logic [15:0] m_cap  [4][$];
    logic [1:0]  m_mode [4];
    logic [15:0] m_cnt  [4];
    logic [15:0] m_const[4];
    bit          m_udf  [4];
    bit          m_ovf  [4];
    logic [15:0] exp_rdata, exp_cd;
    bit          exp_cv, exp_irq;
    bit          m_hit;
    int          m_ch, m_rg;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                m_stim[c].delete();
                m_cap[c].delete();
                m_mode[c] = 2'd0; m_cnt[c] = 16'h0; m_const[c] = 16'hAAAA;
                m_udf[c] = 0; m_ovf[c] = 0;
            end
            exp_rdata = 16'h0; exp_cd = 16'h0; exp_cv = 0; exp_irq = 0;
        end else begin
            m_hit = (bus.addr >= 16'hC000) && (bus.addr < 16'hC010);
            m_ch  = int'(bus.addr[3:2]);
            m_rg  = int'(bus.addr[1:0]);
`ifdef MMSTIM_IRQ_EN
            exp_irq = 0;
            for (int c = 0; c < 4; c++) if (m_udf[c] || m_ovf[c]) exp_irq = 1;
`else
            exp_irq = 0;
`endif
            if (bus.mm_re) begin
                if (!m_hit) exp_rdata = 16'h0;
                else case (m_rg)
                    0: begin
                        if (m_mode[m_ch] == 2'd1) begin
                            exp_rdata = m_cnt[m_ch];
                            m_cnt[m_ch] = m_cnt[m_ch] + 16'h1;
                        end else if (m_mode[m_ch] == 2'd2) exp_rdata = m_const[m_ch];
                        else if (m_stim[m_ch].size() == 0) begin
                            exp_rdata = 16'hAAAA;
                            m_udf[m_ch] = 1;
                        end else exp_rdata = m_stim[m_ch].pop_front();
                    end
                    1: exp_rdata = {10'h0, m_udf[m_ch], m_ovf[m_ch],
                                    m_cap[m_ch].size() == 8, m_cap[m_ch].size() == 0,
                                    m_stim[m_ch].size() == 8, m_stim[m_ch].size() == 0};
                    2: exp_rdata = {14'h0, m_mode[m_ch]};
                    default: exp_rdata = m_cnt[m_ch];
                endcase
            end
            exp_cv = 0;
            if (bus.cap_pop && m_cap[bus.stim_ch].size() > 0) begin
                exp_cv = 1;
                exp_cd = m_cap[bus.stim_ch].pop_front();
            end
            if (bus.stim_push && m_stim[bus.stim_ch].size() < 8)
                m_stim[bus.stim_ch].push_back(bus.stim_data);
            if (bus.mm_we && m_hit) begin
                case (m_rg)
                    0: if (m_cap[m_ch].size() < 8) m_cap[m_ch].push_back(bus.wdata);
                       else m_ovf[m_ch] = 1;
                    2: begin
                        m_mode[m_ch] = bus.wdata[1:0];
                        if (bus.wdata[15]) begin m_udf[m_ch] = 0; m_ovf[m_ch] = 0; end
                    end
                    3: begin m_cnt[m_ch] = bus.wdata; m_const[m_ch] = bus.wdata; end
                    default: ;
                endcase
            end
        end
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("rdata", bus.rdata, exp_rdata);
            chk("cap_valid", bus.cap_valid, exp_cv);
            chk("cap_data", bus.cap_data, exp_cd);
            chk("irq", bus.irq, exp_irq);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #2;
    endtask
    task automatic cpu_rd(input logic [15:0] a);
        bus.addr = a; bus.mm_re = 1'b1; step(); bus.mm_re = 1'b0;
    endtask
    task automatic rd_chk(input logic [15:0] a, input logic [15:0] e, input string nm);
        cpu_rd(a); chk(nm, bus.rdata, e);
    endtask
    task automatic cpu_wr(input logic [15:0] a, input logic [15:0] d);
        bus.addr = a; bus.wdata = d; bus.mm_we = 1'b1; step(); bus.mm_we = 1'b0;
    endtask
    task automatic push(input logic [1:0] c, input logic [15:0] d);
        bus.stim_ch = c; bus.stim_data = d; bus.stim_push = 1'b1; step(); bus.stim_push = 1'b0;
    endtask
    task automatic pop_chk(input logic [1:0] c, input bit ev, input logic [15:0] ed, input string nm);
        bus.stim_ch = c; bus.cap_pop = 1'b1; step(); bus.cap_pop = 1'b0;
        chk({nm, "_v"}, bus.cap_valid, ev);
        if (ev) chk({nm, "_d"}, bus.cap_data, ed);
    endtask
    task automatic rd_push(input logic [15:0] a, input logic [1:0] c, input logic [15:0] d,
                           input logic [15:0] e, input string nm);
        bus.addr = a; bus.mm_re = 1'b1;
        bus.stim_ch = c; bus.stim_data = d; bus.stim_push = 1'b1;
        step();
        bus.mm_re = 1'b0; bus.stim_push = 1'b0;
        chk(nm, bus.rdata, e);
    endtask

    initial begin
        bus.addr = 16'h0; bus.mm_re = 0; bus.mm_we = 0; bus.wdata = 16'h0;
        bus.stim_push = 0; bus.stim_ch = 2'd0; bus.stim_data = 16'h0; bus.cap_pop = 0;
        #12;
        chk("rst_rdata", bus.rdata, 16'h0);
        chk("rst_cap_data", bus.cap_data, 16'h0);
        chk("rst_cap_valid", bus.cap_valid, 1'b0);
        chk("rst_irq", bus.irq, 1'b0);
        @(posedge clk); #2 rst = 1'b0;
        rd_chk(16'hC001, 16'h0005, "rst_status0");
        rd_chk(16'hC003, 16'h0000, "rst_cnt0");
        rd_chk(16'hC00A, 16'h0000, "rst_mode2");

        // FIFO read path
        push(2'd0, 16'h1111);
        push(2'd0, 16'h2222);
        rd_chk(16'hC000, 16'h1111, "fifo_rd0");
        rd_chk(16'hC000, 16'h2222, "fifo_rd1");
        rd_chk(16'hC000, 16'hAAAA, "fifo_rd_empty");
        rd_chk(16'hC001, 16'h0025, "udf_status");
`ifdef MMSTIM_IRQ_EN
        chk("irq_set", bus.irq, 1'b1);
        cpu_wr(16'hC002, 16'h8000);
        chk("irq_hold", bus.irq, 1'b1);
`else
        chk("irq_off", bus.irq, 1'b0);
        cpu_wr(16'hC002, 16'h8000);
`endif
        step();
        chk("irq_clear", bus.irq, 1'b0);
        rd_chk(16'hC001, 16'h0005, "udf_cleared");

        // simultaneous push/pop on an empty FIFO: no bypass
        rd_push(16'hC000, 2'd0, 16'h5555, 16'hAAAA, "empty_rdpush");
        rd_chk(16'hC000, 16'h5555, "after_rdpush");
        cpu_wr(16'hC002, 16'h8000);

        // INCR wrap
        cpu_wr(16'hC007, 16'hFFFE);
        cpu_wr(16'hC006, 16'h0001);
        rd_chk(16'hC004, 16'hFFFE, "incr0");
        rd_chk(16'hC004, 16'hFFFF, "incr1");
        rd_chk(16'hC004, 16'h0000, "incr_wrap");
        rd_chk(16'hC007, 16'h0001, "seed_rd");
        rd_chk(16'hC007, 16'h0001, "seed_rd_noinc");
        rd_chk(16'hC006, 16'h0001, "ctrl_rd");

        // capture overflow
        for (int i = 1; i <= 9; i++) cpu_wr(16'hC008, 16'(i));
        rd_chk(16'hC009, 16'h0019, "ovf_status");
        for (int i = 1; i <= 8; i++) pop_chk(2'd2, 1'b1, 16'(i), "cap_pop");
        pop_chk(2'd2, 1'b0, 16'h0, "cap_pop_empty");
        cpu_wr(16'hC00A, 16'h8000);
        rd_chk(16'hC009, 16'h0005, "ovf_cleared");

        // full ch3 stimulus FIFO: dropped push, then push+pop together
        for (int i = 0; i < 8; i++) push(2'd3, 16'h0030 + 16'(i));
        push(2'd3, 16'hDEAD);
        rd_chk(16'hC00D, 16'h0006, "ch3_full");
        for (int i = 0; i < 4; i++)
            rd_push(16'hC00C, 2'd3, 16'h0038 + 16'(i), 16'h0030 + 16'(i), "full_rdpush");
        rd_chk(16'hC00D, 16'h0006, "ch3_still_full");
        for (int i = 0; i < 8; i++) rd_chk(16'hC00C, 16'h0034 + 16'(i), "ch3_drain");
        rd_chk(16'hC00D, 16'h0005, "ch3_empty");

        // read and write together: read sees pre-write CTRL
        bus.addr = 16'hC00E; bus.wdata = 16'h0002; bus.mm_re = 1; bus.mm_we = 1;
        step(); bus.mm_re = 0; bus.mm_we = 0;
        chk("rdwr_pre", bus.rdata, 16'h0000);
        rd_chk(16'hC00E, 16'h0002, "rdwr_post");
        rd_chk(16'hC00C, 16'hAAAA, "const_rd");

        // window misses
        rd_chk(16'h1234, 16'h0000, "miss_rd");
        cpu_wr(16'hC010, 16'h4444);
        cpu_wr(16'hBFFC, 16'h4444);
        rd_chk(16'hC010, 16'h0000, "miss_hi_rd");
        step();
        chk("idle_hold", bus.rdata, 16'h0000);

        // reset mid-stream
        push(2'd0, 16'h0101);
        push(2'd0, 16'h0202);
        cpu_wr(16'hC004, 16'h7777);
        cpu_wr(16'hC008, 16'h6666);
        pop_chk(2'd2, 1'b1, 16'h6666, "pre_rst_pop");
        rd_chk(16'hC004, 16'h0001, "pre_rst_incr");
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_rdata", bus.rdata, 16'h0);
        chk("mid_rst_cap_data", bus.cap_data, 16'h0);
        chk("mid_rst_cap_valid", bus.cap_valid, 1'b0);
        chk("mid_rst_irq", bus.irq, 1'b0);
        step(); step();
        rst = 1'b0;
        rd_chk(16'hC000, 16'hAAAA, "post_rst_rd");
        rd_chk(16'hC005, 16'h0005, "post_rst_status1");
        rd_chk(16'hC006, 16'h0000, "post_rst_mode1");
        rd_chk(16'hC007, 16'h0000, "post_rst_cnt1");
        pop_chk(2'd1, 1'b0, 16'h0, "post_rst_cap");
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mm_stim_bank.md
# mm_stim_bank

Parametrised memory-mapped stimulus/capture bank that sits on the CPU's data-memory port (`addr`, `mm_re`, `mm_we`, `wdata`, `rdata`) in place of a fixed constant read-data source. It provides NUM_CH independent channels. Each channel has a stimulus FIFO loaded from the bench side and popped by CPU reads, and a capture FIFO filled by CPU writes and drained by the bench. Each channel also has a selectable read mode, so CPU programs can be driven with scripted, counting or constant data and their stores checked.

## Interface
- DATA_W, 16, data width of the CPU and bench ports
- ADDR_W, 16, CPU address width
- NUM_CH, 4, channel count; power of 2, range 1..8
- DEPTH, 8, entries per FIFO; power of 2, at least 2
- BASE_ADDR, 16'hC000, base of the bank window; aligned to 4*NUM_CH
- DEFAULT_DATA, 16'hAAAA, value read from an empty stimulus FIFO and the CONST-mode reset value

Ports:
- clk  in  1  single clock; everything is on the rising edge
- rst  in  1  asynchronous, active-high reset
- addr  in  ADDR_W  CPU address
- mm_re  in  1  CPU read strobe
- mm_we  in  1  CPU write strobe
- wdata  in  DATA_W  CPU write data
- rdata  out  DATA_W  registered CPU read data
- stim_push  in  1  bench push into the stimulus FIFO of channel stim_ch
- stim_ch  in  $clog2(NUM_CH) (min 1)  bench channel select, shared by push and pop
- stim_data  in  DATA_W  bench push data
- cap_pop  in  1  bench pop from the capture FIFO of channel stim_ch
- cap_data  out  DATA_W  registered pop data
- cap_valid  out  1  one-cycle pulse; cap_data is valid
- irq  out  1  error interrupt (see Configuration)

## Operation
- Hit condition: addr is in BASE_ADDR .. BASE_ADDR+4*NUM_CH-1. Channel index is addr[2 +: CH_W]; register select is addr[1:0].
- Registers per channel:
  - 0 DATA
    - Read in mode FIFO: pops the stimulus FIFO; if the FIFO is empty, returns DEFAULT_DATA and sets the sticky `udf` flag.
    - Read in mode INCR: returns the counter, then the counter increments and wraps at 2^DATA_W.
    - Read in mode CONST: returns the const register.
    - Write: pushes wdata into the capture FIFO; if the FIFO is full, the data is dropped and the sticky `ovf` flag is set.
  - 1 STATUS (read-only): {udf, ovf, cap_full, cap_empty, stim_full, stim_empty} in bits [5:0]; remaining bits 0.
  - 2 CTRL: bits [1:0] are the mode (0 FIFO, 1 INCR, 2 CONST, 3 treated as FIFO). A write with bit 15 = 1 clears udf and ovf.
  - 3 SEED: a write loads the INCR counter and the const register. A read returns the counter without incrementing it.
- Only a DATA read (register 0) has a side effect; reads of STATUS, CTRL and SEED have none.
- A read that misses the window returns 0. A write that misses the window is ignored.
- mm_re and mm_we asserted together: the write takes effect and the read returns the pre-write state.
- Bench push into a full stimulus FIFO: dropped, and udf is not affected. Bench pop from an empty capture FIFO: cap_valid stays 0.
- Simultaneous push and pop on the same FIFO:
  - Not empty: both occur and the count is unchanged.
  - Empty: the pop sees empty (DEFAULT_DATA / no cap_valid) and the push is stored. There is no bypass.
- FIFO pointers are log2(DEPTH)+1 bits wide. Full when the MSBs differ and the lower bits are equal.

## Timing
- Reset values:
  - rdata=0, cap_data=0, cap_valid=0, irq=0
  - All FIFOs empty, mode=FIFO, counter=0, const=DEFAULT_DATA, udf=ovf=0
- rdata is valid on the cycle after the mm_re edge and holds until the next mm_re. A read with mm_re=0 does not change rdata.
- cap_data and cap_valid: one cycle after the cap_pop edge.
- Flags and FIFO state update on the same edge as the causing strobe. A STATUS read on the next cycle reflects them.
- Back-to-back DATA reads pop one entry per cycle.
- rst asserted mid-operation clears all state immediately (asynchronously). In-flight reads are lost.

## Configuration
- MMSTIM_IRQ_EN defined: irq is registered and equals the OR over all channels of (udf | ovf). It asserts the cycle after the flag sets and drops the cycle after the flag is cleared by a CTRL write.
- MMSTIM_IRQ_EN undefined: irq is tied to 0 and the OR logic is not built. The flags remain visible in STATUS.

## Test plan
- FIFO read path: bench pushes 16'h1111, 16'h2222 to ch0. The CPU then reads 16'hC000 three times. Required: rdata is 16'h1111, 16'h2222, 16'hAAAA; STATUS bit5 (udf) = 1.
- INCR wrap: write SEED=16'hFFFE and CTRL=1 on ch1, then read 16'hC004 three times. Required: 16'hFFFE, 16'hFFFF, 16'h0000; SEED read = 16'h0001.
- Capture overflow: CPU writes 9 values (1..9) to ch2 DATA with DEPTH=8. Required: ovf=1, and bench pops return 1..8 with cap_valid pulses. A ninth pop gives no cap_valid.
- Simultaneous push/pop on a full ch3 stimulus FIFO: the count stays 8, and the data order is preserved.
- IRQ (with MMSTIM_IRQ_EN): after udf sets, irq=1. Write CTRL=16'h8000 to that channel; irq=0 one cycle later.
- Reset mid-stream: assert rst with FIFOs part-full. Required: every output and flag returns to its reset value, and a subsequent ch0 read returns 16'hAAAA.
